// File: rtl/axis_fifo_sync.sv
// Single-clock AXI-Stream FIFO: (FIFO_DEPTH-1)-entry RAM plus a first-word-fall-through output
// register. Define AXIS_FIFO_SYNC_PACKET_MODE_EN to hold beats back until their tlast is stored.
module axis_fifo_sync #(
  parameter int unsigned FIFO_DEPTH   = 256,
  parameter int unsigned BUS_WIDTH    = 1,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH   = 1,
  parameter int unsigned ALMOST_FULL  = 240,
  parameter int unsigned ALMOST_EMPTY = 16
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [8*BUS_WIDTH-1:0]     s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]       s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [8*BUS_WIDTH-1:0]     m_axis_tdata,
  output logic [BUS_WIDTH-1:0]       m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic [DEST_WIDTH-1:0]      m_axis_tdest,
  output logic [$clog2(FIFO_DEPTH):0] data_count,
  output logic [$clog2(FIFO_DEPTH):0] packet_count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW       = CW - 1;
  localparam int unsigned RamDepth = FIFO_DEPTH - 1;
  localparam int unsigned WordW    = 9 * BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;

  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AfLevel   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AeLevel   = CW'(ALMOST_EMPTY);
  localparam logic [PW-1:0] PtrLast   = PW'(RamDepth - 1);

  logic [WordW-1:0] ram_q [RamDepth];
  logic [WordW-1:0] in_word, out_q, out_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, pkt_q, pkt_d;
  logic             out_valid_q, out_valid_d, ready_q;
  logic             wr_en, rd_en, load, ram_empty, ram_we, release_ok;

  // RAM depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign in_word   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tdest};
  assign wr_en     = s_axis_tvalid && ready_q;
  assign rd_en     = m_axis_tvalid && m_axis_tready;
  assign load      = !out_valid_q || rd_en;
  assign ram_empty = ((count_q - CW'(out_valid_q)) == '0);
  // An incoming beat bypasses the RAM when the output stage takes it directly.
  assign ram_we    = wr_en && !(load && ram_empty);

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    rd_ptr_d    = rd_ptr_q;
    if (load) begin
      if (!ram_empty) begin
        out_valid_d = 1'b1;
        out_d       = ram_q[rd_ptr_q];
        rd_ptr_d    = ptr_inc(rd_ptr_q);
      end else if (wr_en) begin
        out_valid_d = 1'b1;
        out_d       = in_word;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    wr_ptr_d = ram_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    pkt_d = pkt_q;
    unique case ({wr_en && s_axis_tlast, rd_en && m_axis_tlast})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (ram_we) begin
      ram_q[wr_ptr_q] <= in_word;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_q       <= pkt_d;
      ready_q     <= (count_d != FullCount);
    end
  end

`ifdef AXIS_FIFO_SYNC_PACKET_MODE_EN
  logic drain_q, drain_d, override;

  // A full FIFO with no complete packet would deadlock; release beats until the tlast drains.
  assign override   = (count_q == FullCount) && (pkt_q == '0);
  assign release_ok = (pkt_q != '0) || drain_q || override;

  always_comb begin
    drain_d = drain_q;
    if (rd_en && override && !m_axis_tlast) drain_d = 1'b1;
    if ((rd_en && m_axis_tlast) || (count_d == '0)) drain_d = 1'b0;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) drain_q <= 1'b0;
    else      drain_q <= drain_d;
  end
`else
  assign release_ok = 1'b1;
`endif

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = out_q;
  assign m_axis_tvalid = out_valid_q && release_ok;
  assign s_axis_tready = ready_q;
  assign data_count    = count_q;
  assign packet_count  = pkt_q;
  assign almost_full   = (count_q >= AfLevel);
  assign almost_empty  = (count_q <= AeLevel);

endmodule
